// File: rtl/btn_conditioner.sv
// btn_conditioner: raw push-button front end for the step FSM.
// Each channel is synchronised through two flops, normalised so that 1 means
// pressed, and debounced by a small per-channel state machine. A clean press
// produces a single registered pulse on cond; level follows the debounced state.
module btn_conditioner #(
   parameter int N_BTN           = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] cond,
   output logic [N_BTN-1:0] level
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [N_BTN-1:0] RAW_RELEASED = {N_BTN{ACTIVE_LOW}};

   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_HELD         = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   // Maps pad polarity onto "1 = pressed".
   function automatic logic [N_BTN-1:0] pressed_norm(input logic [N_BTN-1:0] raw);
      return ACTIVE_LOW ? ~raw : raw;
   endfunction

   logic [N_BTN-1:0] sync_p0;
   logic [N_BTN-1:0] sync_p1;
   logic [N_BTN-1:0] pressed_p2;

   // Stage p0/p1: two-flop synchroniser; reset parks it at the released level
   // so no phantom press is seen when reset lifts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0 <= RAW_RELEASED;
         sync_p1 <= RAW_RELEASED;
      end else begin
         sync_p0 <= btn_raw;
         sync_p1 <= sync_p0;
      end
   end

   // Stage p2: polarity-normalised synchronised level feeding the debouncers.
   assign pressed_p2 = pressed_norm(sync_p1);

   for (genvar g = 0; g < N_BTN; g++) begin : g_chan
      logic [1:0]       state_q;
      logic [1:0]       state_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             cond_q;
      logic             cond_d;
      logic             level_q;
      logic             level_d;
      logic             p;

      assign p = pressed_p2[g];

      // Debounce next-state: a level change is accepted only after the
      // synchronised input has stayed at the new level for the full count.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         cond_d  = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (p) begin
                  state_d = ST_PRESS_WAIT;
                  cnt_d   = '0;
               end
            end
            ST_PRESS_WAIT: begin
               if (!p) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_HELD;
                  cnt_d   = '0;
                  cond_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_HELD: begin
               if (!p) begin
                  state_d = ST_RELEASE_WAIT;
                  cnt_d   = '0;
               end
            end
            ST_RELEASE_WAIT: begin
               if (p) begin
                  state_d = ST_HELD;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
         level_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
      end

      // Stage p3: registered state, counter, press pulse and debounced level;
      // reset aborts any debounce in progress and clears both outputs at once.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cond_q  <= 1'b0;
            level_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cond_q  <= cond_d;
            level_q <= level_d;
         end
      end

      assign cond[g]  = cond_q;
      assign level[g] = level_q;
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner (N_BTN=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
// Reference model: the synchronised input is a two-edge delay of btn_raw; the
// debounced level flips once the synchronised pressed value has disagreed with
// it on D+1 consecutive edges, and a flip to pressed produces the cond pulse.
module tb_btn_conditioner;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] btn_raw;
   logic [1:0] cond;
   logic [1:0] level;

   btn_conditioner #(
      .N_BTN(2),
      .DEBOUNCE_CYCLES(D),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_raw(btn_raw),
      .cond(cond),
      .level(level)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [1:0] m_h1, m_h2, m_level, m_cond;
   int         m_run [2];

   // Observed-side bookkeeping
   int         pulses [2];
   logic [1:0] ds_state;
   logic [1:0] both_pulse_seen;

   task automatic model_reset();
      m_h1 = 2'b11;
      m_h2 = 2'b11;
      m_level = 2'b00;
      m_cond = 2'b00;
      m_run[0] = 0;
      m_run[1] = 0;
   endtask

   task automatic model_edge(input logic [1:0] raw);
      logic pp;
      for (int c = 0; c < 2; c++) begin
         pp = ~m_h2[c];
         m_cond[c] = 1'b0;
         if (pp != m_level[c]) m_run[c] = m_run[c] + 1;
         else m_run[c] = 0;
         if (m_run[c] == D + 1) begin
            m_level[c] = pp;
            m_cond[c] = pp;
            m_run[c] = 0;
         end
      end
      m_h2 = m_h1;
      m_h1 = raw;
   endtask

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs == exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive raw now (well after the last edge), take the next edge,
   // update the model and compare both outputs.
   task automatic cycle(input logic [1:0] raw, input string tag);
      btn_raw = raw;
      @(posedge clk);
      if (!reset) model_edge(raw);
      #1;
      check({tag, "/cond"}, cond, m_cond);
      check({tag, "/level"}, level, m_level);
      if (cond[0]) pulses[0]++;
      if (cond[1]) pulses[1]++;
      if (cond != 2'b00) ds_state = ds_state + 2'd1;
   endtask

   initial begin
      int p0, p1;
      logic [1:0] ds0;
      logic [1:0] rnd_raw;
      int burst [2];

      pulses[0] = 0;
      pulses[1] = 0;
      ds_state = 2'b00;
      both_pulse_seen = 2'b00;

      // Reset state
      btn_raw = 2'b11;
      reset = 1'b1;
      model_reset();
      #1;
      check("reset_async_cond", cond, 2'b00);
      check("reset_async_level", level, 2'b00);
      repeat (2) @(posedge clk);
      #2;
      check("reset_cond", cond, 2'b00);
      check("reset_level", level, 2'b00);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) cycle(2'b11, "idle");

      // 1: channel 0 press, pulse exactly after edge 6
      p0 = pulses[0];
      for (int i = 0; i < 10; i++) begin
         cycle(2'b10, "t1_press");
         if (i == 5) check("t1_cond_e5", cond, 2'b00);
         if (i == 5) check("t1_level_e5", level, 2'b00);
         if (i == 6) check("t1_cond_e6", cond, 2'b01);
         if (i == 6) check("t1_level_e6", level, 2'b01);
         if (i == 7) check("t1_cond_e7", cond, 2'b00);
      end
      check_int("t1_pulse_count", pulses[0] - p0, 1);
      for (int i = 0; i < 10; i++) begin
         cycle(2'b11, "t1_release");
         if (i == 5) check("t1_rel_level_e5", level, 2'b01);
         if (i == 6) check("t1_rel_level_e6", level, 2'b00);
      end

      // 2: three-cycle glitch on channel 1 is ignored
      for (int i = 0; i < 3; i++) begin
         cycle(2'b01, "t2_glitch");
         check("t2_quiet_g", {cond[1], level[1]}, 2'b00);
      end
      for (int i = 0; i < 8; i++) begin
         cycle(2'b11, "t2_after");
         check("t2_quiet_a", {cond[1], level[1]}, 2'b00);
      end

      // 3: simultaneous press -> cond=11 once, downstream advances once
      ds0 = ds_state;
      for (int i = 0; i < 10; i++) begin
         cycle(2'b00, "t3_both");
         if (i == 6) check("t3_cond_e6", cond, 2'b11);
      end
      check("t3_ds_once", ds_state, ds0 + 2'd1);
      for (int i = 0; i < 10; i++) cycle(2'b11, "t3_release");

      // 4: long hold with a 2-cycle release glitch, then release
      p0 = pulses[0];
      for (int i = 0; i < 50; i++) begin
         cycle((i == 20 || i == 21) ? 2'b11 : 2'b10, "t4_hold");
         if (i >= 6) check("t4_level_held", {1'b0, level[0]}, 2'b01);
      end
      check_int("t4_pulse_count", pulses[0] - p0, 1);
      for (int i = 0; i < 10; i++) begin
         cycle(2'b11, "t4_release");
         if (i == 5) check("t4_level_e5", level, 2'b01);
         if (i == 6) check("t4_level_e6", level, 2'b00);
      end

      // 5: reset mid-PRESS_WAIT with the button still held
      p0 = pulses[0];
      for (int i = 0; i < 5; i++) cycle(2'b10, "t5_pw");
      reset = 1'b1;
      model_reset();
      #1;
      check("t5_rst_cond", cond, 2'b00);
      check("t5_rst_level", level, 2'b00);
      cycle(2'b10, "t5_in_reset");
      cycle(2'b10, "t5_in_reset");
      #1;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle(2'b10, "t5_after");
         if (i == 6) check("t5_cond_e6", cond, 2'b01);
      end
      check_int("t5_pulse_count", pulses[0] - p0, 1);
      // reset while HELD drops level immediately
      check("t5_held_level", level, 2'b01);
      reset = 1'b1;
      model_reset();
      #1;
      check("t5_held_rst_level", level, 2'b00);
      cycle(2'b11, "t5_in_reset2");
      #1;
      reset = 1'b0;
      for (int i = 0; i < 8; i++) cycle(2'b11, "t5_idle");

      // 6: four clean presses -> 4 pulses, downstream 00,01,10,11,00
      ds_state = 2'b00;
      p0 = pulses[0];
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 9; i++) cycle(2'b10, "t6_press");
         check("t6_ds_step", ds_state, 2'(k + 1));
         for (int i = 0; i < 9; i++) cycle(2'b11, "t6_release");
      end
      check_int("t6_pulse_count", pulses[0] - p0, 4);
      check("t6_ds_final", ds_state, 2'b00);

      // Random bursts on both channels against the model
      rnd_raw = 2'b11;
      burst[0] = 1;
      burst[1] = 1;
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < 2; c++) begin
            burst[c] = burst[c] - 1;
            if (burst[c] == 0) begin
               rnd_raw[c] = ~rnd_raw[c];
               burst[c] = $urandom_range(1, 9);
            end
         end
         cycle(rnd_raw, "rand");
      end
      p1 = pulses[1];
      check_int("rand_ch1_active", (p1 > 0) ? 1 : 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
